// File: rtl/steer_pid.sv
// PID steering correction plus ramped forward speed, producing clipped left/right motor speeds.
// Two-stage pipeline: stage 1 saturates the error and updates state; stage 2 forms PID and clips.
module steer_pid #(
  parameter logic [3:0]  P_COEFF   = 4'd3,
  parameter logic [3:0]  D_COEFF   = 4'd6,
  parameter int unsigned D_DEPTH   = 4,
  parameter logic [10:0] FRWRD_INC = 11'd16,
  parameter logic [10:0] MAX_FRWRD = 11'd768,
  parameter logic [11:0] MAX_SPD   = 12'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [15:0] err_opn_lp,
  input  logic        err_vld,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        spd_vld,
  output logic        moving
);

  logic               clr;
  logic signed [9:0]  err_sat;
  logic signed [10:0] d_raw;
  logic signed [7:0]  d_clip;
  logic signed [16:0] integ_sum;
  logic signed [15:0] integ_d;
  logic [11:0]        frwrd_sum;
  logic [10:0]        frwrd_d;

  logic signed [9:0]  hist_q [D_DEPTH];
  logic signed [15:0] integ_q;
  logic [10:0]        frwrd_q;
  logic               s1_vld_q;
  logic signed [9:0]  s1_err_q;
  logic signed [7:0]  s1_dd_q;
  logic [11:0]        lft_q, rght_q;
  logic               spd_vld_q, moving_q;

  logic signed [15:0] p_term, i_term, d_term, pid;
  logic signed [16:0] lsum, rsum;

  assign clr = rst | ~go;

  always_comb begin
    if ($signed(err_opn_lp) > 16'sd511)
      err_sat = 10'sd511;
    else if ($signed(err_opn_lp) < -16'sd512)
      err_sat = -10'sd512;
    else
      err_sat = err_opn_lp[9:0];

    d_raw = $signed({err_sat[9], err_sat}) - $signed({hist_q[D_DEPTH-1][9], hist_q[D_DEPTH-1]});
    if (d_raw > 11'sd127)
      d_clip = 8'sd127;
    else if (d_raw < -11'sd128)
      d_clip = -8'sd128;
    else
      d_clip = d_raw[7:0];

    // Overflow when the two top bits of the 17-bit sum disagree; clamp toward the sign.
    integ_sum = $signed({integ_q[15], integ_q}) + $signed({{7{err_sat[9]}}, err_sat});
    if (integ_sum[16] != integ_sum[15])
      integ_d = integ_sum[16] ? 16'sh8000 : 16'sh7FFF;
    else
      integ_d = integ_sum[15:0];

    frwrd_sum = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
    frwrd_d   = (frwrd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : frwrd_sum[10:0];
  end

  always_comb begin
    p_term = $signed({{6{s1_err_q[9]}}, s1_err_q}) * $signed({12'd0, P_COEFF});
    i_term = integ_q >>> 4;
    d_term = $signed({{8{s1_dd_q[7]}}, s1_dd_q}) * $signed({12'd0, D_COEFF});
    pid    = p_term + i_term + d_term;
    lsum   = $signed({6'd0, frwrd_q}) + $signed({pid[15], pid});
    rsum   = $signed({6'd0, frwrd_q}) - $signed({pid[15], pid});
  end

  function automatic logic [11:0] clip_spd(input logic signed [16:0] v);
    if (v < 17'sd0)
      return '0;
    else if (v > $signed({5'd0, MAX_SPD}))
      return MAX_SPD;
    else
      return v[11:0];
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
      integ_q   <= '0;
      frwrd_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_err_q  <= '0;
      s1_dd_q   <= '0;
      lft_q     <= '0;
      rght_q    <= '0;
      spd_vld_q <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      s1_vld_q  <= err_vld;
      spd_vld_q <= s1_vld_q;
      if (err_vld) begin
        hist_q[0] <= err_sat;
        for (int unsigned k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
        integ_q  <= integ_d;
        frwrd_q  <= frwrd_d;
        moving_q <= (frwrd_d != '0);
        s1_err_q <= err_sat;
        s1_dd_q  <= d_clip;
      end
      if (s1_vld_q) begin
        lft_q  <= clip_spd(lsum);
        rght_q <= clip_spd(rsum);
      end
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign spd_vld  = spd_vld_q;
  assign moving   = moving_q;

endmodule

// File: tb/tb_steer_pid.sv
// Scoreboard bench for steer_pid: the driver pushes expected speeds, a monitor pops on spd_vld.
module tb_steer_pid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b1;
  logic [15:0] err_opn_lp = '0;
  logic        err_vld = 1'b0;
  logic [11:0] lft_spd, rght_spd;
  logic        spd_vld, moving;

  steer_pid #(
    .P_COEFF(4'd3), .D_COEFF(4'd6), .D_DEPTH(4),
    .FRWRD_INC(11'd16), .MAX_FRWRD(11'd768), .MAX_SPD(12'd4095)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .err_opn_lp(err_opn_lp), .err_vld(err_vld),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld), .moving(moving)
  );

  always #5 clk = ~clk;

  typedef struct { int lft; int rght; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_hist[4];
  int m_integ, m_frwrd;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    m_integ = 0;
    m_frwrd = 0;
  endtask

  function automatic int clipi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic exp_t model_step(input int e);
    exp_t r;
    int es, d, pid;
    es = clipi(e, -512, 511);
    d  = clipi(es - m_hist[3], -128, 127);
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = es;
    m_integ = clipi(m_integ + es, -32768, 32767);
    m_frwrd = (m_frwrd + 16 > 768) ? 768 : m_frwrd + 16;
    pid = es * 3 + (m_integ >>> 4) + d * 6;
    r.lft  = clipi(m_frwrd + pid, 0, 4095);
    r.rght = clipi(m_frwrd - pid, 0, 4095);
    return r;
  endfunction

  // Issue one strobe; either use the model or a hand-computed expectation.
  task automatic issue(input int e);
    err_opn_lp = e[15:0];
    err_vld = 1'b1;
    exp_q.push_back(model_step(e));
    tick();
    err_vld = 1'b0;
  endtask

  task automatic issue_hand(input int e, input int l, input int r);
    exp_t x;
    void'(model_step(e));
    x.lft = l; x.rght = r;
    err_opn_lp = e[15:0];
    err_vld = 1'b1;
    exp_q.push_back(x);
    tick();
    err_vld = 1'b0;
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic drop_go();
    go = 1'b0;
    m_clear();
    tick();
    go = 1'b1;
  endtask

  always @(negedge clk) begin
    if (spd_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_spd_vld", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("lft_spd", int'(lft_spd), x.lft);
        chk("rght_spd", int'(rght_spd), x.rght);
        chk("moving_at_vld", int'(moving), 1);
      end
    end
  end

  initial begin
    m_clear();
    // Reset held with go high and err_vld toggling: nothing may come out.
    for (int i = 0; i < 2; i++) begin
      err_vld = (i == 0);
      err_opn_lp = 16'd200;
      tick();
    end
    // A sample already in stage 1 is dropped by reset.
    rst = 1'b0; err_vld = 1'b1; tick();
    rst = 1'b1; err_vld = 1'b0; tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_lft", int'(lft_spd), 0);
    chk("rst_rght", int'(rght_spd), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_vld", int'(spd_vld), 0);

    // Single sample err=100: P=300, I=6, D=600, frwrd=16.
    issue_hand(100, 922, 0);
    drain();

    // Clean ramp with zero error.
    drop_go();
    chk("go_drop_lft", int'(lft_spd), 0);
    chk("go_drop_moving", int'(moving), 0);
    for (int i = 0; i < 60; i++) issue(0);
    drain();
    chk("ramp_lft", int'(lft_spd), 768);
    chk("ramp_rght", int'(rght_spd), 768);
    chk("ramp_moving", int'(moving), 1);

    // err_vld ignored while go is low.
    go = 1'b0; m_clear(); err_opn_lp = 16'd300; err_vld = 1'b1; tick();
    err_vld = 1'b1; tick();
    err_vld = 1'b0; go = 1'b1; tick(); tick();
    chk("go_low_lft", int'(lft_spd), 0);
    chk("go_low_rght", int'(rght_spd), 0);
    chk("go_low_moving", int'(moving), 0);

    // Back-to-back strobes from clean state.
    issue_hand(50, 469, 0);
    issue_hand(-50, 0, 482);
    issue_hand(0, 48, 48);
    drain();

    // Saturation: err clipped to 511, first D clipped to 127, integrator pins at 32767.
    drop_go();
    issue_hand(16'h7FFF, 2342, 0);
    for (int i = 0; i < 69; i++) issue(16'h7FFF);
    drain();
    chk("sat_lft", int'(lft_spd), 4095);
    chk("sat_rght", int'(rght_spd), 0);
    // Error reversal pulls the integrator straight off its limit.
    issue(-32768);
    issue(-32768);
    drain();

    // Restart after go drop begins ramp at 16 again.
    drop_go();
    chk("restart_lft", int'(lft_spd), 0);
    issue_hand(100, 922, 0);
    drain();
    tick(); tick();
    chk("hold_lft", int'(lft_spd), 922);
    chk("hold_vld", int'(spd_vld), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
